// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: branch prediction, branch-queue entry and
// resolution-queue state, plus helpers for evaluating a retiring branch.
package rv32i_types;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } bp_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } br_state_t;

  // ROB tag lives in a separate array so its width can stay a module parameter
  typedef struct packed {
    logic        valid;
    bp_t         pred;
    logic [31:0] pc;
    logic        resolved;
    logic        taken;
    logic [31:0] target;
  } br_entry_t;

  function automatic logic br_correct(input br_entry_t e);
    return ((e.pred == TAKEN) == e.taken);
  endfunction

  function automatic logic [31:0] br_redirect(input br_entry_t e);
    return e.taken ? e.target : (e.pc + 32'd4);
  endfunction

endpackage

// File: rtl/br_tag_cam.sv
// Tag match over all queue slots; returns a one-hot hit vector for the
// candidate (valid, unresolved) entries whose stored tag equals i_tag.
module br_tag_cam #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 5
) (
  input  logic             i_en,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [DEPTH-1:0] i_cand,
  input  logic [TAG_W-1:0] i_tags [DEPTH],
  output logic [DEPTH-1:0] o_hit
);

  always_comb begin
    o_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_hit[i] = i_en && i_cand[i] && (i_tags[i] == i_tag);
    end
  end

endmodule

// File: rtl/br_resolve.sv
// Branch resolution queue: tracks predicted branches, collects out-of-order
// outcomes by ROB tag, retires in order and flushes/redirects on mispredict.
module br_resolve
  import rv32i_types::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [TAG_W-1:0] push_tag,
  input  bp_t              push_pred,
  input  logic [31:0]      push_pc,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             update,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QCNT_W = $clog2(DEPTH + 1);

  br_entry_t         r_q    [DEPTH];
  logic [TAG_W-1:0]  r_tags [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [QCNT_W-1:0] r_count;
  br_state_t         r_state;
  br_state_t         w_state_nxt;
  logic              r_update;
  logic              r_flush;
  logic [31:0]       r_redirect;
  logic [CNT_W-1:0]  r_mcnt;

  br_entry_t         w_head;
  logic              w_run;
  logic              w_retire;
  logic              w_mispred;
  logic              w_pop;
  logic              w_push;
  logic [DEPTH-1:0]  w_cand;
  logic [DEPTH-1:0]  w_hit;

  assign w_head = r_q[r_head];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_cand[i] = r_q[i].valid && !r_q[i].resolved;
    end
  end

  br_tag_cam #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_cam (
    .i_en   (res_valid && w_run),
    .i_tag  (res_tag),
    .i_cand (w_cand),
    .i_tags (r_tags),
    .o_hit  (w_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     w_state_nxt = w_mispred ? RECOVER : RUN;
      RECOVER: w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Head evaluation and fetch handshake; a mispredicting head blocks pushes
  always_comb begin
    w_run      = (r_state == RUN);
    w_retire   = w_run && w_head.valid && w_head.resolved;
    w_mispred  = w_retire && !br_correct(w_head);
    w_pop      = w_retire && !w_mispred;
    push_ready = w_run && (r_count < QCNT_W'(DEPTH)) && !w_mispred;
    w_push     = push_valid && push_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i]    <= '0;
        r_tags[i] <= '0;
      end
    end else if (w_mispred) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_pop && (r_head == PTR_W'(i))) begin
          r_q[i].valid <= 1'b0;
        end
        if (w_hit[i]) begin
          r_q[i].resolved <= 1'b1;
          r_q[i].taken    <= res_taken;
          r_q[i].target   <= res_target;
        end
        if (w_push && (r_tail == PTR_W'(i))) begin
          r_q[i].valid    <= 1'b1;
          r_q[i].pred     <= push_pred;
          r_q[i].pc       <= push_pc;
          r_q[i].resolved <= 1'b0;
          r_q[i].taken    <= 1'b0;
          r_q[i].target   <= 32'd0;
          r_tags[i]       <= push_tag;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_mispred) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + QCNT_W'(1);
        2'b01:   r_count <= r_count - QCNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered recovery outputs; redirect_pc holds its last value between flushes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_update   <= 1'b0;
      r_flush    <= 1'b0;
      r_redirect <= 32'd0;
      r_mcnt     <= '0;
    end else begin
      r_update <= w_mispred;
      r_flush  <= w_mispred;
      if (w_mispred) begin
        r_redirect <= br_redirect(w_head);
        if (r_mcnt != {CNT_W{1'b1}}) begin
          r_mcnt <= r_mcnt + CNT_W'(1);
        end
      end
    end
  end

  assign update         = r_update;
  assign flush          = r_flush;
  assign redirect_pc    = r_redirect;
  assign mispredict_cnt = r_mcnt;

endmodule

// File: tb/tb_br_resolve.sv
// Scoreboard bench for br_resolve: a queue-based reference model predicts
// push_ready every cycle and each flush (cycle, redirect PC, counter value).
module tb_br_resolve;
  import rv32i_types::*;

  localparam int DEPTH = 8;
  localparam int TAG_W = 5;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push_valid = 1'b0;
  logic             push_ready;
  logic [TAG_W-1:0] push_tag = '0;
  bp_t              push_pred = NOT_TAKEN;
  logic [31:0]      push_pc = 32'd0;
  logic             res_valid = 1'b0;
  logic [TAG_W-1:0] res_tag = '0;
  logic             res_taken = 1'b0;
  logic [31:0]      res_target = 32'd0;
  logic             update;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] mispredict_cnt;

  always #5 clk = ~clk;

  br_resolve #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_tag(push_tag),
    .push_pred(push_pred), .push_pc(push_pc),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
    .res_target(res_target),
    .update(update), .flush(flush), .redirect_pc(redirect_pc),
    .mispredict_cnt(mispredict_cnt)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    bp_t              pred;
    logic [31:0]      pc;
    bit               resolved;
    bit               taken;
    logic [31:0]      target;
  } m_ent_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    int          cnt;
  } exp_t;

  m_ent_t mq[$];
  exp_t   sb[$];
  bit     m_rec = 1'b0;
  int     m_cnt = 0;
  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every flush must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        if (flush || update) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_flush: got flush=%0b update=%0b expected none (cycle %0d)",
                     flush, update, cyc);
          end else begin
            e = sb.pop_front();
            check("flush_cycle", cyc, e.cyc);
            check("redirect_pc", redirect_pc, e.pc);
            check("mispredict_cnt", mispredict_cnt, e.cnt);
            check("update_eq_flush", update, flush);
          end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_flush: got none expected flush pc=%0h at cycle %0d", e.pc, e.cyc);
        end
      end
    end
  end

  // One cycle of stimulus; the model advances as if the coming edge occurs
  task automatic step(input bit pv, input logic [TAG_W-1:0] ptag, input bp_t ppred,
                      input logic [31:0] ppc, input bit rv, input logic [TAG_W-1:0] rtag,
                      input bit rtk, input logic [31:0] rtgt);
    bit ret, mis, ready;
    exp_t e;
    @(negedge clk);
    ret   = !m_rec && mq.size() > 0 && mq[0].resolved;
    mis   = ret && ((mq[0].pred == TAKEN) != mq[0].taken);
    ready = !m_rec && mq.size() < DEPTH && !mis;
    check("push_ready", push_ready, ready);
    push_valid = pv;  push_tag = ptag;  push_pred = ppred;  push_pc = ppc;
    res_valid  = rv;  res_tag  = rtag;  res_taken = rtk;    res_target = rtgt;
    if (m_rec) begin
      m_rec = 1'b0;
    end else if (mis) begin
      e.cyc = cyc + 1;
      e.pc  = mq[0].taken ? mq[0].target : mq[0].pc + 32'd4;
      if (m_cnt < CNT_MAX) m_cnt++;
      e.cnt = m_cnt;
      sb.push_back(e);
      mq.delete();
      m_rec = 1'b1;
    end else begin
      if (ret) void'(mq.pop_front());
      if (rv) begin
        foreach (mq[i]) begin
          if (!mq[i].resolved && mq[i].tag == rtag) begin
            mq[i].resolved = 1'b1;
            mq[i].taken    = rtk;
            mq[i].target   = rtgt;
            break;
          end
        end
      end
      if (pv && ready) mq.push_back('{ptag, ppred, ppc, 1'b0, 1'b0, 32'd0});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, NOT_TAKEN, 32'd0, 1'b0, '0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    push_valid = 1'b0;
    res_valid  = 1'b0;
    #1;
    check("rst_update", update, 0);
    check("rst_flush", flush, 0);
    check("rst_redirect", redirect_pc, 0);
    check("rst_cnt", mispredict_cnt, 0);
    mq.delete();
    sb.delete();
    m_rec = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [TAG_W-1:0] free_tag();
    logic [TAG_W-1:0] t;
    bit used;
    do begin
      t = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
      used = 1'b0;
      foreach (mq[i]) if (mq[i].tag == t) used = 1'b1;
    end while (used);
    return t;
  endfunction

  initial begin
    do_reset();

    // correct taken branch retires silently
    step(1'b1, 5'd3, TAKEN, 32'h100, 1'b0, '0, 1'b0, 32'd0);
    step(1'b0, '0, NOT_TAKEN, 32'd0, 1'b1, 5'd3, 1'b1, 32'h200);
    idle(3);

    // predicted taken, actually not taken -> redirect pc+4
    step(1'b1, 5'd1, TAKEN, 32'h40, 1'b0, '0, 1'b0, 32'd0);
    step(1'b0, '0, NOT_TAKEN, 32'd0, 1'b1, 5'd1, 1'b0, 32'h999);
    idle(4);

    // out-of-order resolution, in-order retire
    for (int k = 1; k <= 3; k++)
      step(1'b1, TAG_W'(k), TAKEN, 32'h1000 + 32'(k * 4), 1'b0, '0, 1'b0, 32'd0);
    step(1'b0, '0, NOT_TAKEN, 32'd0, 1'b1, 5'd3, 1'b1, 32'h3000);
    step(1'b0, '0, NOT_TAKEN, 32'd0, 1'b1, 5'd2, 1'b1, 32'h3000);
    idle(2);
    step(1'b0, '0, NOT_TAKEN, 32'd0, 1'b1, 5'd1, 1'b1, 32'h3000);
    idle(4);

    // fill the queue, then the head mispredicts to 0x8000
    for (int k = 0; k < DEPTH; k++)
      step(1'b1, TAG_W'(10 + k), NOT_TAKEN, 32'h2000 + 32'(k * 4), 1'b0, '0, 1'b0, 32'd0);
    step(1'b1, 5'd18, NOT_TAKEN, 32'h2100, 1'b1, 5'd10, 1'b1, 32'h8000);
    step(1'b1, 5'd19, NOT_TAKEN, 32'h2104, 1'b0, '0, 1'b0, 32'd0);
    idle(4);

    // reset while recovering
    for (int k = 0; k < 4; k++)
      step(1'b1, TAG_W'(20 + k), TAKEN, 32'h500 + 32'(k * 4), 1'b0, '0, 1'b0, 32'd0);
    step(1'b0, '0, NOT_TAKEN, 32'd0, 1'b1, 5'd20, 1'b0, 32'd0);
    step(1'b0, '0, NOT_TAKEN, 32'd0, 1'b0, '0, 1'b0, 32'd0);
    do_reset();

    // unknown tag on an empty queue
    step(1'b0, '0, NOT_TAKEN, 32'd0, 1'b1, 5'd9, 1'b1, 32'h1234);
    idle(3);

    // counter saturation
    for (int k = 0; k < CNT_MAX + 2; k++) begin
      step(1'b1, 5'd4, TAKEN, 32'hFFFF_FFFC, 1'b0, '0, 1'b0, 32'd0);
      step(1'b0, '0, NOT_TAKEN, 32'd0, 1'b1, 5'd4, 1'b0, 32'd0);
      idle(3);
    end

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      bit pv, rv, rtk;
      logic [TAG_W-1:0] ptag, rtag;
      bp_t ppred;
      int cand[$];
      pv    = ($urandom_range(0, 3) != 0);
      ptag  = free_tag();
      ppred = bp_t'($urandom_range(0, 1));
      rv    = ($urandom_range(0, 1) == 1);
      rtag  = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
      rtk   = $urandom_range(0, 1) == 1;
      foreach (mq[i]) if (!mq[i].resolved) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 9) < 7) begin
        int idx;
        idx  = cand[$urandom_range(0, cand.size() - 1)];
        rtag = mq[idx].tag;
        rtk  = ($urandom_range(0, 9) == 0) ? (mq[idx].pred != TAKEN) : (mq[idx].pred == TAKEN);
      end
      step(pv, ptag, ppred, $urandom() & 32'hFFFF_FFFC, rv, rtag, rtk, $urandom());
    end

    idle(5);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
